semaforo_ctrl: RTL and testbench

//  Upstream traffic-light sequencer for the two-road crossing. Generates the vehicle light

---
 rtl/semaforo_ctrl.sv | 168 ++++++++++++++++
 tb/tb_semaforo_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/semaforo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : semaforo_ctrl
//  Purpose  : Two-road traffic-light sequencer. Moore FSM plus phase counter
//             produces the vehicle light codes consumed by the downstream
//             pedestrian-signal stage. Latched pedestrian requests may cut a
//             green phase short once its minimum length has elapsed.
//             Light code: 00 = red, 01 = yellow, 10 = green (11 never driven).
//  Ports    : clk     rising-edge clock
//             rst     synchronous reset, active low (priority over all inputs)
//             enb     advance enable; low freezes state, counter and latches
//             req_A   pedestrian request to cross road A (level)
//             req_B   pedestrian request to cross road B (level)
//             semA    road A light code
//             semB    road B light code
//             phase   current state encoding (debug)
//  Config   : SEM_ALL_RED_EN - when defined, an all-red clearance phase of
//             T_ALLRED cycles follows each yellow.
//  Revision : 1.0 - initial release
// ============================================================================
module semaforo_ctrl #(
    parameter int T_GREEN     = 4,
    parameter int T_GREEN_MIN = 2,
    parameter int T_YELLOW    = 1,
    parameter int T_ALLRED    = 1,
    parameter int CW          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       req_A,
    input  logic       req_B,
    output logic [1:0] semA,
    output logic [1:0] semB,
    output logic [2:0] phase
);

    // Parameter sanity check at elaboration time.
    if ((T_GREEN < 1) || (T_GREEN > (1 << CW)) || (T_GREEN_MIN < 1) ||
        (T_GREEN_MIN > T_GREEN) || (T_YELLOW < 1) || (T_YELLOW > (1 << CW)) ||
        (T_ALLRED < 1) || (T_ALLRED > (1 << CW))) begin : g_param_check
        $error("semaforo_ctrl: phase length parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_B_GREEN  = 3'd1,
        ST_B_YELLOW = 3'd2,
        ST_RED_BA   = 3'd3,
        ST_A_GREEN  = 3'd4,
        ST_A_YELLOW = 3'd5,
        ST_RED_AB   = 3'd6
    } state_t;

    localparam logic [1:0] c_RED    = 2'b00;
    localparam logic [1:0] c_YELLOW = 2'b01;
    localparam logic [1:0] c_GREEN  = 2'b10;

    // Last counter value of each phase (a phase of length T exits at cnt==T-1).
    localparam logic [CW-1:0] c_GREEN_LAST  = CW'(T_GREEN - 1);
    localparam logic [CW-1:0] c_GMIN_LAST   = CW'(T_GREEN_MIN - 1);
    localparam logic [CW-1:0] c_YELLOW_LAST = CW'(T_YELLOW - 1);
`ifdef SEM_ALL_RED_EN
    localparam logic [CW-1:0] c_ALLRED_LAST = CW'(T_ALLRED - 1);
`endif

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req_a;
    logic          r_req_b;

    state_t        w_next;
    logic          w_clr_a;
    logic          w_clr_b;
    logic [CW-1:0] w_cnt_next;

    // Next-state logic. Every transition goes to a different state, so a
    // state change is exactly a state entry and restarts the counter.
    always_comb begin
        w_next  = r_state;
        w_clr_a = 1'b0;
        w_clr_b = 1'b0;
        case (r_state)
            ST_INIT: w_next = ST_B_GREEN;
            ST_B_GREEN: begin
                // The latch is registered, so a request raised on this edge
                // only shortens the phase from the following cycle on.
                if ((r_cnt == c_GREEN_LAST) || (r_req_b && (r_cnt >= c_GMIN_LAST))) begin
                    w_next  = ST_B_YELLOW;
                    w_clr_b = 1'b1;
                end
            end
            ST_B_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST) begin
`ifdef SEM_ALL_RED_EN
                    w_next = ST_RED_BA;
`else
                    w_next = ST_A_GREEN;
`endif
                end
            end
            ST_A_GREEN: begin
                if ((r_cnt == c_GREEN_LAST) || (r_req_a && (r_cnt >= c_GMIN_LAST))) begin
                    w_next  = ST_A_YELLOW;
                    w_clr_a = 1'b1;
                end
            end
            ST_A_YELLOW: begin
                if (r_cnt == c_YELLOW_LAST) begin
`ifdef SEM_ALL_RED_EN
                    w_next = ST_RED_AB;
`else
                    w_next = ST_B_GREEN;
`endif
                end
            end
`ifdef SEM_ALL_RED_EN
            ST_RED_BA: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    w_next = ST_A_GREEN;
                end
            end
            ST_RED_AB: begin
                if (r_cnt == c_ALLRED_LAST) begin
                    w_next = ST_B_GREEN;
                end
            end
`endif
            default: w_next = ST_INIT;
        endcase
        w_cnt_next = (w_next != r_state) ? '0 : (r_cnt + CW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_req_a <= 1'b0;
            r_req_b <= 1'b0;
        end else if (enb) begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            // Clear on yellow entry dominates a simultaneous new request.
            r_req_a <= w_clr_a ? 1'b0 : (r_req_a | req_A);
            r_req_b <= w_clr_b ? 1'b0 : (r_req_b | req_B);
        end
    end

    // Moore output decode straight from the state register.
    always_comb begin
        semA = c_RED;
        semB = c_RED;
        case (r_state)
            ST_B_GREEN:  semB = c_GREEN;
            ST_B_YELLOW: semB = c_YELLOW;
            ST_A_GREEN:  semA = c_GREEN;
            ST_A_YELLOW: semA = c_YELLOW;
            default: begin
                semA = c_RED;
                semB = c_RED;
            end
        endcase
    end

    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_semaforo_ctrl
//  Purpose  : Self-checking bench for semaforo_ctrl (default build, all-red
//             phases disabled). Table of per-edge vectors plus a held-request
//             sequence measuring green lengths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_semaforo_ctrl;

    logic       clk;
    logic       rst;
    logic       enb;
    logic       req_A;
    logic       req_B;
    logic [1:0] semA;
    logic [1:0] semB;
    logic [2:0] phase;

    semaforo_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .enb   (enb),
        .req_A (req_A),
        .req_B (req_B),
        .semA  (semA),
        .semB  (semB),
        .phase (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {semA, semB, phase} after an edge.
    localparam logic [6:0] S_INIT = {2'b00, 2'b00, 3'd0};
    localparam logic [6:0] S_BG   = {2'b00, 2'b10, 3'd1};
    localparam logic [6:0] S_BY   = {2'b00, 2'b01, 3'd2};
    localparam logic [6:0] S_AG   = {2'b10, 2'b00, 3'd4};
    localparam logic [6:0] S_AY   = {2'b01, 2'b00, 3'd5};

    typedef struct packed {
        logic       rst;
        logic       enb;
        logic       ra;
        logic       rb;
        logic [6:0] exp;
    } vec_t;

    vec_t tv[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic addn(input int n, input logic r, input logic e,
                        input logic qa, input logic qb, input logic [6:0] ex);
        vec_t v;
        v.rst = r; v.enb = e; v.ra = qa; v.rb = qb; v.exp = ex;
        for (int i = 0; i < n; i++) tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [6:0] act, input logic [6:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%0d]: got semA=%b semB=%b phase=%0d, expected semA=%b semB=%b phase=%0d",
                      name, idx, act[6:5], act[4:3], act[2:0], req[6:5], req[4:3], req[2:0]);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Waits for phase==ph then counts consecutive cycles in it (bounded).
    task automatic measure(input logic [2:0] ph, output int len);
        int guard;
        len   = 0;
        guard = 0;
        while (phase !== ph && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        while (phase === ph && len < 40) begin
            @(posedge clk); #1; len++;
        end
    endtask

    initial begin
        int a_len, b_len;
        rst = 1'b0; enb = 1'b1; req_A = 1'b0; req_B = 1'b0;

        // Reset held two edges, then release.
        addn(2, 0, 1, 0, 0, S_INIT);
        // Free run, no requests: period 10.
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(4, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(1, 1, 1, 0, 0, S_AG);
        // req_A pulse in first A green cycle: green shortened to 2.
        addn(1, 1, 1, 1, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        // Following A green full length.
        addn(4, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        // enb low 3 cycles in second A green cycle; req_B ignored while frozen.
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(2, 1, 1, 0, 0, S_AG);
        addn(3, 1, 0, 0, 1, S_AG);
        addn(2, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        // req_B raised during B yellow stays pending: next B green is 2.
        addn(1, 1, 1, 0, 1, S_AG);
        addn(3, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        addn(2, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        // req_A on the yellow-entry edge: clear wins, next A green full.
        addn(4, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 1, 0, S_AY);
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(4, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);
        // Pending req_A, then reset in B yellow (enb low): request dropped.
        addn(3, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 1, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(1, 0, 0, 0, 0, S_INIT);
        addn(4, 1, 1, 0, 0, S_BG);
        addn(1, 1, 1, 0, 0, S_BY);
        addn(4, 1, 1, 0, 0, S_AG);
        addn(1, 1, 1, 0, 0, S_AY);

        // Reset value before any release.
        @(posedge clk); #1;
        check("reset_state", -1, {semA, semB, phase}, S_INIT);

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst; enb = tv[i].enb; req_A = tv[i].ra; req_B = tv[i].rb;
            @(posedge clk); #1;
            check("vec", i, {semA, semB, phase}, tv[i].exp);
            if (semA == 2'b10 && semB == 2'b10) begin
                n_total++;
                $display("FAIL both_green[%0d]: got semA=%b semB=%b, expected not both 10", i, semA, semB);
            end
        end

        // Held req_A: every A green is cut to the 2-cycle minimum, B stays 4.
        @(negedge clk);
        req_A = 1'b1;
        measure(3'd4, a_len);
        check_int("held_reqA_green1", a_len, 2);
        measure(3'd1, b_len);
        check_int("held_reqA_bgreen", b_len, 4);
        measure(3'd4, a_len);
        check_int("held_reqA_green2", a_len, 2);
        req_A = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
